sandbox_channel_router: RTL

//  Parametrised successor to the single-DUT sandbox harness: byte-framed request/response router between the

---
 rtl/sandbox_channel_router.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sandbox_channel_router.sv
// Byte-framed router between a UART byte interface and CHANNELS independent DUT processes.
// Host frame = header (channel) + WIDTH_BYTES payload; reply = header + response, or a lone error byte.
module sandbox_channel_router #(
  parameter int CHANNELS     = 4,
  parameter int WIDTH_BYTES  = 6,
  parameter int GAP_TIMEOUT  = 120000,
  parameter int RESP_TIMEOUT = 12000000
) (
  input  logic                              masterClock,
  input  logic                              reset,
  input  logic [7:0]                        rxByte,
  input  logic                              rxValid,
  output logic [7:0]                        txByte,
  output logic                              txStart,
  input  logic                              txBusy,
  output logic [WIDTH_BYTES*8-1:0]          chInputData,
  output logic [CHANNELS-1:0]               chDataReceived,
  input  logic [CHANNELS-1:0]               chClearDR,
  input  logic [CHANNELS-1:0]               chTransmit,
  input  logic [CHANNELS*WIDTH_BYTES*8-1:0] chOutputData,
  output logic                              busy,
  output logic [7:0]                        errorCount,
  output logic [2:0]                        dbgState
);
  localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW        = WIDTH_BYTES * 8;
  localparam int GAP_BITS  = $clog2(GAP_TIMEOUT + 1);
  localparam int RESP_BITS = $clog2(RESP_TIMEOUT + 1);
  localparam int CNT_BITS  = $clog2(WIDTH_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RX_PAYLOAD, S_WAIT_RESP, S_TX_HDR, S_TX_DATA, S_TX_WAIT
  } state_t;

  // Handshake: rxValid is a one-cycle byte strobe; txStart is issued only while txBusy is low,
  // and the next byte waits until txStart has retired and txBusy has fallen again.
  state_t               state_q, state_d;
  logic [7:0]           hdr_q, hdr_d;
  logic [DW-1:0]        rx_buf_q, rx_buf_d;
  logic [CNT_BITS-1:0]  rx_cnt_q, rx_cnt_d;
  logic [GAP_BITS-1:0]  gap_q, gap_d;
  logic [RESP_BITS-1:0] resp_cnt_q, resp_cnt_d;
  logic [DW-1:0]        resp_q, resp_d;
  logic [7:0]           reply_hdr_q, reply_hdr_d;
  logic [CNT_BITS-1:0]  tx_rem_q, tx_rem_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 tx_start_q, tx_start_d;
  logic [DW-1:0]        ch_in_q, ch_in_d;
  logic [CHANNELS-1:0]  ch_dr_q, ch_dr_d;
  logic [7:0]           err_cnt_q, err_cnt_d;

  logic [CH_BITS-1:0]   ch_sel;
  logic                 hdr_valid;
  logic [CHANNELS-1:0]  ch_onehot;
  logic                 err_event;

  assign ch_sel    = hdr_q[CH_BITS-1:0];
  assign hdr_valid = ~hdr_q[7] && (32'(hdr_q) < 32'(CHANNELS));
  assign ch_onehot = CHANNELS'(1) << ch_sel;

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    rx_buf_d    = rx_buf_q;
    rx_cnt_d    = rx_cnt_q;
    gap_d       = gap_q;
    resp_cnt_d  = resp_cnt_q;
    resp_d      = resp_q;
    reply_hdr_d = reply_hdr_q;
    tx_rem_d    = tx_rem_q;
    tx_byte_d   = tx_byte_q;
    tx_start_d  = 1'b0;
    ch_in_d     = ch_in_q;
    ch_dr_d     = ch_dr_q & ~chClearDR;
    // A byte arriving while we are not parsing a frame is lost and counted.
    err_event   = rxValid && (state_q != S_IDLE) && (state_q != S_RX_PAYLOAD);

    unique case (state_q)
      S_IDLE: begin
        if (rxValid) begin
          hdr_d    = rxByte;
          rx_cnt_d = '0;
          gap_d    = '0;
          state_d  = S_RX_PAYLOAD;
        end
      end
      S_RX_PAYLOAD: begin
        if (rxValid) begin
          rx_buf_d[(WIDTH_BYTES - 1 - 32'(rx_cnt_q)) * 8 +: 8] = rxByte;
          rx_cnt_d = rx_cnt_q + 1'b1;
          gap_d    = '0;
          if (rx_cnt_q == CNT_BITS'(WIDTH_BYTES - 1)) begin
            if (hdr_valid) begin
              ch_in_d    = rx_buf_d;
              ch_dr_d    = ch_onehot;
              resp_cnt_d = '0;
              state_d    = S_WAIT_RESP;
            end else begin
              err_event   = 1'b1;
              reply_hdr_d = 8'hFF;
              tx_rem_d    = '0;
              state_d     = S_TX_HDR;
            end
          end
        end else if (gap_q >= GAP_BITS'(GAP_TIMEOUT)) begin
          err_event = 1'b1;
          state_d   = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_WAIT_RESP: begin
        // A response in the timeout cycle still wins over the timeout.
        if (chTransmit[ch_sel]) begin
          resp_d      = chOutputData[32'(ch_sel) * DW +: DW];
          ch_dr_d     = '0;
          reply_hdr_d = hdr_q;
          tx_rem_d    = CNT_BITS'(WIDTH_BYTES);
          if (!txBusy) begin
            tx_start_d = 1'b1;
            tx_byte_d  = hdr_q;
            state_d    = S_TX_WAIT;
          end else begin
            state_d = S_TX_HDR;
          end
        end else if (resp_cnt_q >= RESP_BITS'(RESP_TIMEOUT)) begin
          ch_dr_d     = '0;
          err_event   = 1'b1;
          reply_hdr_d = 8'h80 | hdr_q;
          tx_rem_d    = '0;
          state_d     = S_TX_HDR;
        end else begin
          resp_cnt_d = resp_cnt_q + 1'b1;
        end
      end
      S_TX_HDR: begin
        if (!txBusy) begin
          tx_start_d = 1'b1;
          tx_byte_d  = reply_hdr_q;
          state_d    = S_TX_WAIT;
        end
      end
      S_TX_DATA: begin
        if (!txBusy) begin
          tx_start_d = 1'b1;
          tx_byte_d  = resp_q[DW-1 -: 8];
          resp_d     = resp_q << 8;
          tx_rem_d   = tx_rem_q - 1'b1;
          state_d    = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        // txBusy may still show the previous byte's low level while txStart is in flight.
        if (!tx_start_q && !txBusy) begin
          state_d = (tx_rem_q != '0) ? S_TX_DATA : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_cnt_d = (err_event && (err_cnt_q != 8'hFF)) ? err_cnt_q + 1'b1 : err_cnt_q;
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      rx_buf_q    <= '0;
      rx_cnt_q    <= '0;
      gap_q       <= '0;
      resp_cnt_q  <= '0;
      resp_q      <= '0;
      reply_hdr_q <= '0;
      tx_rem_q    <= '0;
      tx_byte_q   <= '0;
      tx_start_q  <= 1'b0;
      ch_in_q     <= '0;
      ch_dr_q     <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      rx_buf_q    <= rx_buf_d;
      rx_cnt_q    <= rx_cnt_d;
      gap_q       <= gap_d;
      resp_cnt_q  <= resp_cnt_d;
      resp_q      <= resp_d;
      reply_hdr_q <= reply_hdr_d;
      tx_rem_q    <= tx_rem_d;
      tx_byte_q   <= tx_byte_d;
      tx_start_q  <= tx_start_d;
      ch_in_q     <= ch_in_d;
      ch_dr_q     <= ch_dr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign txByte         = tx_byte_q;
  assign txStart        = tx_start_q;
  assign chInputData    = ch_in_q;
  assign chDataReceived = ch_dr_q;
  assign busy           = (state_q != S_IDLE);
  assign errorCount     = err_cnt_q;
  assign dbgState       = state_q;
endmodule
